rggen_axi4lite_apb_bridge: RTL

Single-outstanding AXI4-Lite slave to APB3/APB4 master bridge. It sits directly upstream of the generated register blocks and drives their apb_if, so an AXI4-Lite interconnect can reach the register map. It buffers AW/W/AR channels, arbitrates between reads and writes, sequences the APB SETUP/ACCESS phases and returns B/R responses.

---
 rtl/rggen_bridge_pkg.sv | 30 +++
 rtl/rggen_axi4lite_slot.sv | 50 +++++
 rtl/rggen_axi4lite_apb_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_bridge_pkg.sv
// ---------------------------------------------------------------------------
// rggen_bridge_pkg
// Shared types and constants for the AXI4-Lite to APB bridge:
//   - bridge_state_e : APB sequencing FSM states
//   - bridge_prio_e  : read/write alternating priority flag
//   - RESP_OKAY / RESP_SLVERR : AXI response encodings
//   - flip_prio()    : toggles the priority flag
// ---------------------------------------------------------------------------
package rggen_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10,
      RESP   = 2'b11
   } bridge_state_e;

   typedef enum logic {
      READ_NEXT  = 1'b0,
      WRITE_NEXT = 1'b1
   } bridge_prio_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic bridge_prio_e flip_prio(input bridge_prio_e p);
      return (p == READ_NEXT) ? WRITE_NEXT : READ_NEXT;
   endfunction

endpackage

// File: rtl/rggen_axi4lite_slot.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_slot
// One-entry valid/ready holding register. The slot accepts a payload whenever
// it is empty and keeps it until the owning transaction is retired through
// i_release (the B/R handshake), not merely until it is issued on APB.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_valid     : upstream valid
//   o_ready     : upstream ready (slot empty)
//   i_data      : upstream payload
//   i_release   : frees the slot
//   o_full      : slot holds a payload
//   o_data      : held payload
// ---------------------------------------------------------------------------
module rggen_axi4lite_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_release,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   assign o_ready = ~r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;

   // Capture on handshake; release only happens while full, so the two never collide.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= {WIDTH{1'b0}};
      end else if (i_release) begin
         r_full <= 1'b0;
      end else if (i_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else begin
         r_full <= r_full;
      end
   end

endmodule

// File: rtl/rggen_axi4lite_apb_bridge.sv
// ---------------------------------------------------------------------------
// rggen_axi4lite_apb_bridge
// Single-outstanding AXI4-Lite slave to APB master bridge.
// AW, W and AR are each buffered in a one-entry slot; a write becomes eligible
// once AW and W are both present, a read once AR is present. The FSM picks one
// request (alternating when both are eligible), runs APB SETUP/ACCESS, then
// holds the B or R response until it is accepted, which frees the slot(s).
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   i_aw*/o_awready, i_w*/o_wready  : AXI write address / data channels
//   o_bvalid, i_bready, o_bresp     : AXI write response channel
//   i_ar*/o_arready                 : AXI read address channel
//   o_rvalid, i_rready, o_rdata/rresp : AXI read data channel
//   o_p*, i_pready/prdata/pslverr   : APB master
// ---------------------------------------------------------------------------
module rggen_axi4lite_apb_bridge
   import rggen_bridge_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_awvalid,
   output logic                     o_awready,
   input  logic [ADDRESS_WIDTH-1:0] i_awaddr,
   input  logic                     i_wvalid,
   output logic                     o_wready,
   input  logic [DATA_WIDTH-1:0]    i_wdata,
   input  logic [STRB_WIDTH-1:0]    i_wstrb,
   output logic                     o_bvalid,
   input  logic                     i_bready,
   output logic [1:0]               o_bresp,
   input  logic                     i_arvalid,
   output logic                     o_arready,
   input  logic [ADDRESS_WIDTH-1:0] i_araddr,
   output logic                     o_rvalid,
   input  logic                     i_rready,
   output logic [DATA_WIDTH-1:0]    o_rdata,
   output logic [1:0]               o_rresp,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic                     o_pwrite,
   output logic [DATA_WIDTH-1:0]    o_pwdata,
   output logic [STRB_WIDTH-1:0]    o_pstrb,
   input  logic                     i_pready,
   input  logic [DATA_WIDTH-1:0]    i_prdata,
   input  logic                     i_pslverr
);

   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);
   localparam int WBUS_WIDTH = DATA_WIDTH + STRB_WIDTH;

   bridge_state_e r_state;
   bridge_prio_e  r_prio;
   logic                     r_psel;
   logic                     r_penable;
   logic [ADDRESS_WIDTH-1:0] r_paddr;
   logic                     r_pwrite;
   logic [DATA_WIDTH-1:0]    r_pwdata;
   logic [STRB_WIDTH-1:0]    r_pstrb;
   logic                     r_bvalid;
   logic                     r_rvalid;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic [1:0]               r_resp;

   logic                     w_aw_full;
   logic [ADDRESS_WIDTH-1:0] w_aw_data;
   logic                     w_w_full;
   logic [WBUS_WIDTH-1:0]    w_w_data;
   logic                     w_ar_full;
   logic [ADDRESS_WIDTH-1:0] w_ar_data;

   logic                     w_b_hs;
   logic                     w_r_hs;

   assign w_b_hs = r_bvalid & i_bready;
   assign w_r_hs = r_rvalid & i_rready;

   rggen_axi4lite_slot #(.WIDTH(ADDRESS_WIDTH)) u_aw_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_awvalid),
      .o_ready   (o_awready),
      .i_data    (i_awaddr),
      .i_release (w_b_hs),
      .o_full    (w_aw_full),
      .o_data    (w_aw_data)
   );

   rggen_axi4lite_slot #(.WIDTH(WBUS_WIDTH)) u_w_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_wvalid),
      .o_ready   (o_wready),
      .i_data    ({i_wstrb, i_wdata}),
      .i_release (w_b_hs),
      .o_full    (w_w_full),
      .o_data    (w_w_data)
   );

   rggen_axi4lite_slot #(.WIDTH(ADDRESS_WIDTH)) u_ar_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (i_arvalid),
      .o_ready   (o_arready),
      .i_data    (i_araddr),
      .i_release (w_r_hs),
      .o_full    (w_ar_full),
      .o_data    (w_ar_data)
   );

   // A request arriving this cycle is visible to IDLE directly so SETUP
   // follows the accepting edge without an extra cycle.
   logic                     w_aw_avail;
   logic                     w_w_avail;
   logic                     w_ar_avail;
   logic [ADDRESS_WIDTH-1:0] w_aw_addr;
   logic [WBUS_WIDTH-1:0]    w_w_bus;
   logic [ADDRESS_WIDTH-1:0] w_ar_addr;

   assign w_aw_avail = w_aw_full | i_awvalid;
   assign w_w_avail  = w_w_full  | i_wvalid;
   assign w_ar_avail = w_ar_full | i_arvalid;
   assign w_aw_addr  = w_aw_full ? w_aw_data : i_awaddr;
   assign w_w_bus    = w_w_full  ? w_w_data  : {i_wstrb, i_wdata};
   assign w_ar_addr  = w_ar_full ? w_ar_data : i_araddr;

   logic                     w_write_elig;
   logic                     w_read_elig;
   logic                     w_pick_write;
   logic                     w_start;
   logic [ADDRESS_WIDTH-1:0] w_sel_addr;

   // Request selection: alternate between reads and writes when both are eligible.
   always_comb begin
      w_write_elig = w_aw_avail & w_w_avail;
      w_read_elig  = w_ar_avail;
      w_pick_write = 1'b0;
      if (w_write_elig && w_read_elig) begin
         w_pick_write = (r_prio == WRITE_NEXT);
      end else if (w_write_elig) begin
         w_pick_write = 1'b1;
      end else begin
         w_pick_write = 1'b0;
      end
      w_start    = w_write_elig | w_read_elig;
      w_sel_addr = (w_pick_write ? w_aw_addr : w_ar_addr) & ~ADDR_MASK;
   end

   // APB sequencing FSM with all APB and AXI response outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_prio    <= READ_NEXT;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= {ADDRESS_WIDTH{1'b0}};
         r_pwrite  <= 1'b0;
         r_pwdata  <= {DATA_WIDTH{1'b0}};
         r_pstrb   <= {STRB_WIDTH{1'b0}};
         r_bvalid  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= {DATA_WIDTH{1'b0}};
         r_resp    <= RESP_OKAY;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_prio   <= flip_prio(r_prio);
                  r_paddr  <= w_sel_addr;
                  r_pwrite <= w_pick_write;
                  r_pwdata <= w_pick_write ? w_w_bus[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
                  r_pstrb  <= w_pick_write ? w_w_bus[WBUS_WIDTH-1:DATA_WIDTH] : {STRB_WIDTH{1'b0}};
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (i_pready) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_resp    <= i_pslverr ? RESP_SLVERR : RESP_OKAY;
                  if (r_pwrite) begin
                     r_bvalid <= 1'b1;
                  end else begin
                     r_rvalid <= 1'b1;
                     r_rdata  <= i_prdata;
                  end
                  r_state <= RESP;
               end
            end
            RESP: begin
               if (w_b_hs || w_r_hs) begin
                  r_bvalid <= 1'b0;
                  r_rvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign o_psel    = r_psel;
   assign o_penable = r_penable;
   assign o_paddr   = r_paddr;
   assign o_pwrite  = r_pwrite;
   assign o_pwdata  = r_pwdata;
   assign o_pstrb   = r_pstrb;
   assign o_bvalid  = r_bvalid;
   assign o_bresp   = r_resp;
   assign o_rvalid  = r_rvalid;
   assign o_rdata   = r_rdata;
   assign o_rresp   = r_resp;

endmodule
